// File: rtl/fifo_sync.sv
//------------------------------------------------------------------------------
// Module      : fifo_sync (with RAM_2Port storage)
// Description : Single-clock FIFO controller wrapping a dual-port RAM, with
//               occupancy count, full/empty/almost flags and ovf/udf pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module RAM_2Port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    // Write port
    input  logic                     i_wr_clk,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic                     i_wr_dv,
    input  logic [WIDTH-1:0]         i_wr_data,
    // Read port
    input  logic                     i_rd_clk,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    input  logic                     i_rd_en,
    output logic                     o_rd_dv,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_dv;

    always_ff @(posedge i_wr_clk) begin
        if (i_wr_dv) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register is intentionally unreset so it maps onto block RAM.
    always_ff @(posedge i_rd_clk) begin
        r_rd_dv <= i_rd_en;
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dv   = r_rd_dv;
    assign o_rd_data = r_rd_data;

endmodule

module fifo_sync #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    // Producer side
    input  logic                   i_wr_dv,
    input  logic [WIDTH-1:0]       i_wr_data,
    // Consumer side
    input  logic                   i_rd_en,
    output logic                   o_rd_dv,
    output logic [WIDTH-1:0]       o_rd_data,
    // Status
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_af,
    output logic                   o_ae,
    output logic                   o_ovf,
    output logic                   o_udf
);

    localparam int                 c_ADDR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_ADDR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_LVL  = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE_LVL  = c_CNT_W'(AE_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);

    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_af;
    logic                r_ae;
    logic                r_rd_dv;
    logic                r_ovf;
    logic                r_udf;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [WIDTH-1:0]    w_ram_rd_data;
    logic                w_unused_ram_rd_dv;

    // Acceptance uses the registered flags, so a full FIFO rejects a write
    // even when a read drains a slot in the same cycle (and vice versa).
    assign w_wr_acc = i_wr_dv & ~r_full;
    assign w_rd_acc = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are derived from the next count so they move on the same edge
    // as o_count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= (AF_LEVEL <= 0);
            r_ae     <= 1'b1;
            r_rd_dv  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= c_AF_LVL);
            r_ae    <= (w_count_nxt <= c_AE_LVL);
            r_rd_dv <= w_rd_acc;
            r_ovf   <= i_wr_dv & r_full;
            r_udf   <= i_rd_en & r_empty;
        end
    end

    // The RAM's own valid is unreset, so the locally reset copy is used.
    RAM_2Port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_wr_clk  (i_clk),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dv   (w_wr_acc),
        .i_wr_data (i_wr_data),
        .i_rd_clk  (i_clk),
        .i_rd_addr (r_rd_ptr),
        .i_rd_en   (w_rd_acc),
        .o_rd_dv   (w_unused_ram_rd_dv),
        .o_rd_data (w_ram_rd_data)
    );

    assign o_rd_dv   = r_rd_dv;
    assign o_rd_data = w_ram_rd_data;
    assign o_count   = r_count;
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_af      = r_af;
    assign o_ae      = r_ae;
    assign o_ovf     = r_ovf;
    assign o_udf     = r_udf;

endmodule

`default_nettype wire
